// File: rtl/acc_seq_ctrl.sv
// Sequencer for the conv/argmax accelerator: streams weights from a ROM, then feeds
// padded pixel groups and captures one max_index result per group.
module acc_seq_ctrl #(
  parameter int unsigned NUM_WLOAD = 81,
  parameter int unsigned GROUP_LEN = 10,
  parameter int unsigned PAD_CYC   = 2,
  parameter int unsigned WA_W      = 7
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            start,
  input  logic            skip_wload,
  input  logic [7:0]      num_groups,
  output logic [WA_W-1:0] w_addr,
  input  logic [15:0]     w_data,
  input  logic [15:0]     px_data,
  input  logic            px_valid,
  output logic            px_ready,
  output logic [15:0]     acc_rm,
  output logic [15:0]     acc_rn,
  input  logic [3:0]      acc_max_index,
  output logic            busy,
  output logic            res_valid,
  output logic [3:0]      res_index,
  output logic [7:0]      res_group,
  output logic            done
);

  localparam int unsigned WC_W = 8;
  localparam int unsigned BC_W = $clog2(GROUP_LEN + 1);
  localparam int unsigned PC_W = $clog2(PAD_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WLOAD, S_WGAP, S_FEED, S_PAD, S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [BC_W-1:0] bcnt_q, bcnt_d;
  logic [PC_W-1:0] pcnt_q, pcnt_d;
  logic [7:0]      gcnt_q, gcnt_d;
  logic [7:0]      ng_q, ng_d;

  logic [WA_W-1:0] w_addr_d;
  logic [15:0]     rm_d, rn_d;
  logic            px_ready_d, busy_d, res_valid_d, done_d;
  logic [3:0]      res_index_d;
  logic [7:0]      res_group_d;

  // State, counters and all outputs are registered together
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      bcnt_q    <= '0;
      pcnt_q    <= '0;
      gcnt_q    <= '0;
      ng_q      <= '0;
      w_addr    <= '0;
      acc_rm    <= '0;
      acc_rn    <= '0;
      px_ready  <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_index <= '0;
      res_group <= '0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bcnt_q    <= bcnt_d;
      pcnt_q    <= pcnt_d;
      gcnt_q    <= gcnt_d;
      ng_q      <= ng_d;
      w_addr    <= w_addr_d;
      acc_rm    <= rm_d;
      acc_rn    <= rn_d;
      px_ready  <= px_ready_d;
      busy      <= busy_d;
      res_valid <= res_valid_d;
      res_index <= res_index_d;
      res_group <= res_group_d;
      done      <= done_d;
    end
  end

  // Next state and next output values; outputs describe the following cycle
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    bcnt_d      = bcnt_q;
    pcnt_d      = pcnt_q;
    gcnt_d      = gcnt_q;
    ng_d        = ng_q;
    w_addr_d    = '0;
    rm_d        = '0;
    rn_d        = '0;
    res_valid_d = 1'b0;
    res_index_d = res_index;
    res_group_d = res_group;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          ng_d   = num_groups;
          gcnt_d = '0;
          wcnt_d = '0;
          bcnt_d = '0;
          if (!skip_wload)          state_d = S_WLOAD;
          else if (num_groups == 8'd0) state_d = S_FIN;
          else                      state_d = S_FEED;
        end
      end

      // wcnt k presents address k; ROM word k-1 arrived this cycle and is written next
      S_WLOAD: begin
        wcnt_d = wcnt_q + WC_W'(1);
        if (32'(wcnt_q) + 32'd1 < NUM_WLOAD) w_addr_d = WA_W'(wcnt_q + WC_W'(1));
        if (wcnt_q != '0) begin
          rm_d = w_data;
          rn_d = {8'd0, 7'(wcnt_q), 1'b0};
        end
        if (32'(wcnt_q) == NUM_WLOAD) state_d = S_WGAP;
      end

      S_WGAP: begin
        bcnt_d  = '0;
        state_d = (ng_q == 8'd0) ? S_FIN : S_FEED;
      end

      S_FEED: begin
        rm_d = acc_rm;
        if (px_valid && px_ready) begin
          rm_d   = px_data;
          rn_d   = 16'h0001;
          bcnt_d = bcnt_q + BC_W'(1);
          if (32'(bcnt_q) + 32'd1 == GROUP_LEN) begin
            pcnt_d  = '0;
            state_d = S_PAD;
          end
        end
      end

      S_PAD: begin
        pcnt_d = pcnt_q + PC_W'(1);
        if (32'(pcnt_q) + 32'd1 == PAD_CYC) begin
          res_index_d = acc_max_index;
          res_group_d = gcnt_q;
          res_valid_d = 1'b1;
          gcnt_d      = gcnt_q + 8'd1;
          bcnt_d      = '0;
          if ({1'b0, gcnt_q} + 9'd1 == {1'b0, ng_q}) state_d = S_FIN;
          else                                     state_d = S_FEED;
        end
      end

      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    px_ready_d = (state_d == S_FEED);
    busy_d     = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_acc_seq_ctrl.sv
// Directed bench for acc_seq_ctrl: weight load stream, pixel groups, results, start/reset corner cases.
module tb_acc_seq_ctrl;

  localparam int unsigned NUM_WLOAD = 81;
  localparam int unsigned GROUP_LEN = 10;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        skip_wload = 1'b0;
  logic [7:0]  num_groups = 8'd0;
  logic [6:0]  w_addr;
  logic [15:0] w_data;
  logic [15:0] px_data = 16'd0;
  logic        px_valid = 1'b0;
  logic        px_ready;
  logic [15:0] acc_rm, acc_rn;
  logic [3:0]  acc_max_index = 4'd0;
  logic        busy, res_valid, done;
  logic [3:0]  res_index;
  logic [7:0]  res_group;

  int n_checks = 0;
  int n_err    = 0;

  acc_seq_ctrl #(
    .NUM_WLOAD(81), .GROUP_LEN(10), .PAD_CYC(2), .WA_W(7)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start(start), .skip_wload(skip_wload),
    .num_groups(num_groups), .w_addr(w_addr), .w_data(w_data),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .acc_rm(acc_rm), .acc_rn(acc_rn), .acc_max_index(acc_max_index),
    .busy(busy), .res_valid(res_valid), .res_index(res_index),
    .res_group(res_group), .done(done)
  );

  always #5 clk_i = ~clk_i;

  // Synchronous weight ROM: ROM[k] = 16'h7F00 | k
  always @(posedge clk_i) w_data <= 16'h7F00 | 16'(w_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({w_addr, acc_rm, acc_rn, px_ready, busy, res_valid, res_index, res_group, done});
  endfunction

  // One run from start to done; rel counts cycles after the edge that accepts start
  task automatic run(input bit skip, input logic [7:0] ng, input bit toggle,
                     input int inject_at, input int abort_at, input int exp_groups);
    int exp_wen = 1, wr_cnt = 0, in_seen = 0, in_grp = 0, grp = 0;
    int res_cnt = 0, done_cnt = 0, ready_cnt = 0, dcnt = 0;
    int gap_rel = -10, last_in_rel = -10, done_rel = -10;
    bit prev_beat = 1'b0, prev_ready = 1'b0;
    logic [15:0] prev_data = '0, prev_rm = '0, pix = 16'd10;
    logic [3:0]  mi_exp = '0;

    skip_wload = skip;
    num_groups = ng;
    px_valid   = 1'b0;
    px_data    = pix;
    start      = 1'b1;
    tick();
    start      = 1'b0;
    num_groups = 8'd200;

    for (int rel = 0; rel < 3000; rel++) begin
      if (rel == 0 && !skip) chk("waddr_first", 64'(w_addr), 64'd0);
      if (acc_rn[7:1] != 7'd0) wr_cnt++;
      if (!skip && exp_wen <= int'(NUM_WLOAD) && (exp_wen > 1 || acc_rn[7:1] != 7'd0)) begin
        if (exp_wen == 1) chk("wr_first_rel", 64'(rel), 64'd2);
        chk("wr_rn", 64'(acc_rn), 64'(exp_wen * 2));
        chk("wr_rm", 64'(acc_rm), 64'(32'h7F00 + exp_wen - 1));
        if (exp_wen == int'(NUM_WLOAD)) gap_rel = rel + 1;
        exp_wen++;
      end
      if (rel == gap_rel) chk("gap_rn", 64'(acc_rn), 64'd0);
      if (acc_rn[0]) in_seen++;
      if (prev_beat) begin
        chk("in_rn", 64'(acc_rn), 64'd1);
        chk("in_rm", 64'(acc_rm), 64'(prev_data));
        in_grp++;
        pix = pix + 16'd1;
        if (in_grp == int'(GROUP_LEN)) last_in_rel = rel;
      end else if (prev_ready) begin
        chk("bubble_rn", 64'(acc_rn), 64'd0);
        chk("bubble_rm", 64'(acc_rm), 64'(prev_rm));
      end
      if (rel == last_in_rel + 1) begin
        chk("pad1_rn", 64'(acc_rn), 64'd0);
        chk("pad1_ready", 64'(px_ready), 64'd0);
      end
      if (rel == last_in_rel + 2) begin
        chk("pad2_rn", 64'(acc_rn), 64'd0);
        chk("res_valid", 64'(res_valid), 64'd1);
        chk("res_group", 64'(res_group), 64'(grp));
        chk("res_index", 64'(res_index), 64'(mi_exp));
        chk("group_len", 64'(in_grp), 64'(GROUP_LEN));
        grp++;
        in_grp = 0;
      end
      if (res_valid) res_cnt++;
      if (px_ready) ready_cnt++;
      if (done) begin
        done_cnt++;
        done_rel = rel;
        chk("done_busy", 64'(busy), 64'd0);
      end

      if (rel == abort_at) begin
        px_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        chk("abort_outs", all_outs(), 64'd0);
        repeat (4) begin
          tick();
          if (done) dcnt++;
        end
        chk("abort_no_done", 64'(dcnt), 64'd0);
        chk("abort_idle", 64'(busy), 64'd0);
        return;
      end

      px_valid      = toggle ? ((rel % 2) == 0) : 1'b1;
      px_data       = pix;
      acc_max_index = 4'(rel * 7 + 3);
      start         = (rel == inject_at);
      if (rel == inject_at) num_groups = 8'd5;
      if (rel == last_in_rel + 1) mi_exp = acc_max_index;
      prev_beat  = px_ready && px_valid;
      prev_ready = px_ready;
      prev_data  = px_data;
      prev_rm    = acc_rm;
      if (done_cnt > 0 && rel >= done_rel + 3) break;
      tick();
    end
    start    = 1'b0;
    px_valid = 1'b0;

    chk("done_count", 64'(done_cnt), 64'd1);
    chk("res_count", 64'(res_cnt), 64'(exp_groups));
    chk("write_count", 64'(wr_cnt), skip ? 64'd0 : 64'(NUM_WLOAD));
    chk("in_count", 64'(in_seen), 64'(exp_groups * int'(GROUP_LEN)));
    if (skip && ng == 8'd0) begin
      chk("empty_done_rel", 64'(done_rel), 64'd1);
      chk("empty_ready", 64'(ready_cnt), 64'd0);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_outs", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(busy), 64'd0);

    run(1'b0, 8'd1, 1'b0, -1, -1, 1);   // weight load then one group
    run(1'b1, 8'd3, 1'b0, -1, -1, 3);   // three back-to-back groups
    run(1'b1, 8'd2, 1'b1, -1, -1, 2);   // bubbly pixel stream
    run(1'b0, 8'd2, 1'b0, 10, -1, 2);   // start during weight load ignored
    run(1'b1, 8'd3, 1'b0, -1, 20, 0);   // reset mid-feed
    run(1'b1, 8'd1, 1'b0, -1, -1, 1);   // normal run after abort
    run(1'b1, 8'd0, 1'b0, -1, -1, 0);   // empty run
    chk("hold_index", 64'(res_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
